// File: rtl/dial_pkg.sv
// Shared types and constants for the dial-rotation processor.
// ASCII byte classes, parser states and direction encoding.
package dial_pkg;

  localparam int DIST_W_DEF = 16;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DIGITS,
    SKIP
  } pstate_e;

  function automatic logic is_digit(
    input logic [7:0] b
  );
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/move_parser_if.sv
// Byte-in / move-out handshake bundle of the move parser.
// slave = parser side, master = driving/consuming side.
interface move_parser_if
  import dial_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              move_valid;
  logic              move_dir;
  logic [DIST_W-1:0] move_dist;
  logic              move_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output move_valid,
    output move_dir,
    output move_dist,
    input  move_ready
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  move_valid,
    input  move_dir,
    input  move_dist,
    output move_ready
  );

endinterface

// File: rtl/dec_accum.sv
// Decimal accumulate step: acc*10 + d with exact overflow.
// Computed in DIST_W+4 bits so no carry is ever lost.
module dec_accum
  import dial_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF
) (
  input  logic [DIST_W-1:0] acc_i,
  input  logic [3:0]        dig_i,
  output logic [DIST_W-1:0] sum_o,
  output logic              ovf_o
);

  logic [DIST_W+3:0] acc_w;
  logic [DIST_W+3:0] wide;

  assign acc_w = {4'b0000, acc_i};

  // shift-add form of the multiply by ten
  assign wide = (acc_w << 3)
              + (acc_w << 1)
              + {{DIST_W{1'b0}}, dig_i};

  assign sum_o = wide[DIST_W-1:0];
  assign ovf_o = |wide[DIST_W+3:DIST_W];

endmodule

// File: rtl/move_parser.sv
// ASCII move-line parser: "L68\n" -> (dir, dist) moves.
// One-deep output register, error/move counters, done flag.
module move_parser
  import dial_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  move_parser_if.slave     bus,
  output logic [CNT_W-1:0] move_count,
  output logic [ERR_W-1:0] err_count,
  output logic             done
);

  pstate_e           state_q, state_d;
  logic              dir_q, dir_d;
  logic [DIST_W-1:0] acc_q, acc_d;
  logic              nd_q, nd_d;
  logic              sl_q, sl_d;

  logic              mv_valid_q;
  logic              mv_dir_q;
  logic [DIST_W-1:0] mv_dist_q;

  logic [CNT_W-1:0]  mcnt_q;
  logic [ERR_W-1:0]  ecnt_q;
  logic              done_q;

  logic              acc_en;
  logic              pop;
  logic              emit;
  logic              err_inc;
  logic              b_lr;
  logic              b_dig;
  logic              b_lf;
  logic              b_cr;
  logic              b_dir;
  logic [DIST_W-1:0] sum;
  logic              ovf;

  assign bus.in_ready = ~sl_q
                      & (~mv_valid_q | bus.move_ready);

  assign acc_en = bus.in_valid & bus.in_ready;
  assign pop    = mv_valid_q & bus.move_ready;

  assign b_lr  = (bus.in_data == CH_L)
               | (bus.in_data == CH_R);
  assign b_dig = is_digit(bus.in_data);
  assign b_lf  = (bus.in_data == CH_LF);
  assign b_cr  = (bus.in_data == CH_CR);
  assign b_dir = (bus.in_data == CH_R) ? DIR_R : DIR_L;

  dec_accum #(
    .DIST_W (DIST_W)
  ) u_dec (
    .acc_i (acc_q),
    .dig_i (bus.in_data[3:0]),
    .sum_o (sum),
    .ovf_o (ovf)
  );

  // line-parse next state; in_last closes the line after the byte
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    acc_d   = acc_q;
    nd_d    = nd_q;
    sl_d    = sl_q;
    emit    = 1'b0;
    err_inc = 1'b0;
    if (acc_en) begin
      if (!b_cr) begin
        unique case (state_q)
          IDLE: begin
            unique case (1'b1)
              b_lr: begin
                dir_d   = b_dir;
                acc_d   = '0;
                nd_d    = 1'b0;
                state_d = DIGITS;
              end
              b_lf: state_d = IDLE;
              default: begin
                state_d = SKIP;
                err_inc = 1'b1;
              end
            endcase
          end
          DIGITS: begin
            unique case (1'b1)
              b_dig: begin
                if (ovf) begin
                  state_d = SKIP;
                  err_inc = 1'b1;
                end else begin
                  acc_d = sum;
                  nd_d  = 1'b1;
                end
              end
              b_lf: begin
                state_d = IDLE;
                emit    = nd_q;
                err_inc = ~nd_q;
              end
              default: begin
                state_d = SKIP;
                err_inc = 1'b1;
              end
            endcase
          end
          SKIP: begin
            if (b_lf) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
      if (bus.in_last) begin
        if (state_d == DIGITS) begin
          emit    = nd_d;
          err_inc = ~nd_d;
        end
        state_d = IDLE;
        sl_d    = 1'b1;
      end
    end
  end

  // parser state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_L;
      acc_q   <= '0;
      nd_q    <= 1'b0;
      sl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      nd_q    <= nd_d;
      sl_q    <= sl_d;
    end
  end

  // output move register; reload on emit even while popping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_valid_q <= 1'b0;
      mv_dir_q   <= DIR_L;
      mv_dist_q  <= '0;
    end else if (emit) begin
      mv_valid_q <= 1'b1;
      mv_dir_q   <= dir_d;
      mv_dist_q  <= acc_d;
    end else if (pop) begin
      mv_valid_q <= 1'b0;
    end
  end

  // saturating move / error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      if (pop && (mcnt_q != '1))
        mcnt_q <= mcnt_q + 1'b1;
      if (err_inc && (ecnt_q != '1))
        ecnt_q <= ecnt_q + 1'b1;
    end
  end

  // sticky completion once the stream ended and drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_q | (sl_q & ~mv_valid_q);
    end
  end

  assign bus.move_valid = mv_valid_q;
  assign bus.move_dir   = mv_dir_q;
  assign bus.move_dist  = mv_dist_q;
  assign move_count     = mcnt_q;
  assign err_count      = ecnt_q;
  assign done           = done_q;

endmodule

// File: tb/tb_move_parser.sv
// Bench for move_parser: directed lines plus random streams
// checked against a line-level string model.
module tb_move_parser;
  import dial_pkg::*;

  localparam int DW     = 16;
  localparam int MAXD   = (1 << DW) - 1;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   move_count;
  logic [7:0]    err_count;
  logic          done;

  always #5 clk = ~clk;

  move_parser_if #(.DIST_W(DW)) bus ();

  move_parser #(
    .DIST_W (DW),
    .CNT_W  (16),
    .ERR_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .move_count (move_count),
    .err_count  (err_count),
    .done       (done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // line-level reference model
  string       cur;
  bit          sl_m;
  bit          done_m;
  int unsigned mc_m;
  int unsigned ec_m;
  bit          exp_dir[$];
  int unsigned exp_dist[$];
  logic [7:0]  stim[$];

  task automatic model_reset();
    cur    = "";
    sl_m   = 0;
    done_m = 0;
    mc_m   = 0;
    ec_m   = 0;
    exp_dir.delete();
    exp_dist.delete();
  endtask

  // a line is a move iff: L|R then >=1 digits, value <= MAXD
  task automatic end_line(output bit emitted);
    bit      ok;
    bit      d;
    longint  v;
    byte     c;
    emitted = 0;
    if (cur.len() == 0) return;
    ok = 1;
    v  = 0;
    c  = cur[0];
    d  = (c == "R");
    if (cur.len() < 2 || !(c == "L" || c == "R"))
      ok = 0;
    for (int i = 1; i < cur.len() && ok; i++) begin
      c = cur[i];
      if (c < "0" || c > "9") ok = 0;
      else begin
        v = v * 10 + (c - "0");
        if (v > MAXD) ok = 0;
      end
    end
    cur = "";
    if (ok) begin
      exp_dir.push_back(d);
      exp_dist.push_back(int'(v));
      emitted = 1;
    end else begin
      ec_m++;
    end
  endtask

  task automatic model_byte(
    input  logic [7:0] b,
    input  logic       last,
    output bit         emitted
  );
    bit e;
    emitted = 0;
    if (b == CH_LF) begin
      end_line(e);
      emitted = e;
    end else if (b != CH_CR) begin
      cur = $sformatf("%s%c", cur, b);
    end
    if (last) begin
      end_line(e);
      emitted = emitted | e;
      sl_m = 1;
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++)
      stim.push_back(8'(s[i]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.in_data    = 8'h00;
    bus.move_ready = 1'($urandom);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.move_valid, 0);
    chk("rst_dir",   bus.move_dir,   0);
    chk("rst_dist",  bus.move_dist,  0);
    chk("rst_mcnt",  move_count,     0);
    chk("rst_ecnt",  err_count,      0);
    chk("rst_done",  done,           0);
    chk("rst_irdy",  bus.in_ready,   1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // drive stim, check every cycle against the model
  task automatic run(
    input bit use_last,
    input int vpct,
    input int rpct,
    input int stall_n
  );
    int          idx   = 0;
    int          cyc   = 0;
    int          stall = 0;
    bit          armed = (stall_n > 0);
    bit          pend  = 0;
    bit          hold  = 0;
    bit          e;
    logic        pdir  = 0;
    logic [15:0] pdist = 0;
    bit          fin   = 0;
    while (!fin && cyc < BUDGET) begin
      @(negedge clk);
      if (armed && bus.move_valid) begin
        stall = stall_n;
        armed = 0;
      end
      if (stall > 0) begin
        bus.move_ready = 1'b0;
        stall--;
      end else begin
        bus.move_ready = ($urandom_range(99) < rpct);
      end
      if (idx < stim.size() && $urandom_range(99) < vpct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = stim[idx];
        bus.in_last  = use_last && (idx == stim.size() - 1);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'($urandom);
      end
      #1;
      if (pend) chk("emit_lat", bus.move_valid, 1);
      if (hold) begin
        chk("hold_valid", bus.move_valid, 1);
        chk("hold_dir",   bus.move_dir,   pdir);
        chk("hold_dist",  bus.move_dist,  pdist);
      end
      chk("done", done, done_m);
      done_m = done_m | (sl_m && !bus.move_valid);
      chk("in_ready", bus.in_ready,
          !sl_m && (!bus.move_valid || bus.move_ready));
      if (bus.move_valid && bus.move_ready) begin
        if (exp_dir.size() == 0) begin
          chk("spurious_move", 1, 0);
        end else begin
          chk("move_dir",  bus.move_dir,  exp_dir.pop_front());
          chk("move_dist", bus.move_dist, exp_dist.pop_front());
          mc_m++;
        end
      end
      hold  = bus.move_valid && !bus.move_ready;
      pdir  = bus.move_dir;
      pdist = bus.move_dist;
      pend  = 0;
      if (bus.in_valid && bus.in_ready) begin
        model_byte(bus.in_data, bus.in_last, e);
        pend = e;
        idx++;
      end
      cyc++;
      if (idx == stim.size() && !pend && !hold) begin
        if (use_last) fin = (done === 1'b1);
        else fin = !bus.move_valid && exp_dir.size() == 0;
      end
    end
    if (!fin) chk("timeout", 1, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("move_count", move_count, mc_m);
    chk("err_count",  err_count,  ec_m);
    chk("exp_left",   exp_dir.size(), 0);
    stim.delete();
  endtask

  task automatic gen_line(input bit term);
    int    k = $urandom_range(9);
    int    v;
    int    r;
    string s;
    byte   d;
    d = $urandom_range(1) ? "R" : "L";
    r = $urandom_range(4);
    v = (r == 0) ? 0 : (r == 1) ? MAXD : (r == 2) ? MAXD + 1 :
        (r == 3) ? $urandom_range(99) : $urandom_range(70000);
    case (k)
      0, 1, 2, 3: s = $sformatf("%c%0d", d, v);
      4: s = $sformatf("%c%06d", d, v);
      5: s = "";
      6: s = $sformatf("%c", d);
      7: s = $urandom_range(1) ? $sformatf("X%0d", v)
                               : $sformatf("%c12#3", d);
      8: s = $sformatf("%c1234567", d);
      default: s = $sformatf("%c4\r2", d);
    endcase
    push_str(s);
    if (term) push_str($urandom_range(1) ? "\r\n" : "\n");
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.in_last    = 1'b0;
    bus.move_ready = 1'b0;
    model_reset();
    do_reset();

    push_str("L68\n");
    run(0, 100, 100, 0);

    push_str("R48\r\nL5\n");
    run(0, 100, 100, 6);

    push_str("R65535\nR65536\nL1\n");
    run(0, 100, 100, 0);

    push_str("X12\nL\n\nR7\n");
    run(0, 100, 100, 0);

    do_reset();
    push_str("R9");
    run(1, 100, 100, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = "L";
      #1;
      chk("done_sticky", done, 1);
      chk("last_irdy",   bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;

    do_reset();
    push_str("R12");
    run(0, 100, 100, 0);
    do_reset();
    push_str("L3\n");
    run(0, 100, 100, 0);

    for (int t = 0; t < 6; t++) begin
      bit ul = (t % 2 == 1);
      int n  = $urandom_range(20, 50);
      do_reset();
      for (int i = 0; i < n; i++)
        gen_line(!(ul && i == n - 1 && $urandom_range(1) == 1));
      run(ul, $urandom_range(30, 100),
          $urandom_range(20, 100), $urandom_range(3));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/move_parser.md
Name: move_parser

Overview:
Upstream stage of the dial-rotation processor. Consumes a raw ASCII byte stream of puzzle lines ("L68\n", "R48\r\n", ...) one byte per cycle. Emits one decoded move (direction, distance) per valid line on a valid/ready handshake that connects directly to the rotation stage's valid/direction/distance/ready ports. Holds one output move, counts moves and malformed lines, and signals end-of-stream completion.

Parameters:
DIST_W, 16, distance width; must match the downstream distance port
CNT_W, 16, width of move_count (saturating)
ERR_W, 8, width of err_count (saturating)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_data valid
in_data  input  8  ASCII byte
in_last  input  1  marks final byte of stream; qualified by in_valid
in_ready  output  1  byte accepted when in_valid && in_ready
move_valid  output  1  decoded move present
move_dir  output  1  1 = R, 0 = L
move_dist  output  DIST_W  decimal distance
move_ready  input  1  downstream accepts when move_valid && move_ready
move_count  output  CNT_W  moves accepted downstream
err_count  output  ERR_W  malformed lines discarded
done  output  1  sticky: stream ended and last move drained

Behaviour:
- Reset values: move_valid=0, move_dir=0, move_dist=0, move_count=0, err_count=0, done=0; state=IDLE; in_ready=1.
- in_ready = !seen_last && (!move_valid || move_ready). Combinational from move_ready only, never from in_data.
- Byte classes: 'L'(0x4C), 'R'(0x52), '0'-'9'(0x30-0x39), LF(0x0A), CR(0x0D), other.
- CR is ignored in every state.
- FSM states:
  - IDLE: L/R latches dir, clears acc, goes to DIGITS. LF stays in IDLE (empty line, no error). Digit or other byte goes to SKIP with err++.
  - DIGITS: digit sets acc = acc*10 + d. If the result exceeds 2^DIST_W-1, go to SKIP with err++. LF with ndigits>0 emits the move and goes to IDLE. LF with ndigits=0 is an error and goes to IDLE. L/R/other goes to SKIP with err++.
  - SKIP: discard bytes until LF, then go to IDLE.
- Emit: move register loaded on the clock edge that accepts the terminating byte. move_valid rises the next cycle (latency 1).
- Back-to-back: if an emit and a downstream accept occur in the same cycle, the register reloads and move_valid stays high with no bubble.
- move_valid, move_dir and move_dist stay stable until accepted.
- in_last acts as a terminator after the byte itself is processed:
  - DIGITS with ndigits>0 (including a last digit byte): emit.
  - DIGITS with ndigits=0: err++.
  - IDLE or SKIP: nothing emitted.
  - Then seen_last=1, in_ready=0 until reset.
- done rises the cycle after seen_last && !move_valid. It is sticky.
- Overflow detection is exact in DIST_W+4 bits. An overflowing line is discarded entirely and never clamped.
- move_count increments on each downstream accept. Both counters saturate at all-ones.
- Reset at any time clears the partial line, the pending move, the counters, seen_last and done.

Decomposition:
- Shared package dial_pkg:
  - ASCII constants CH_L, CH_R, CH_0, CH_9, CH_LF, CH_CR
  - DIST_W default
  - parser state enum {IDLE, DIGITS, SKIP}
  - dir encoding constants DIR_L=0, DIR_R=1
- One sub-module, dec_accum: combinational acc*10+d, implemented as (acc<<3)+(acc<<1)+d, with an overflow flag. Parameterised by DIST_W.

Test Plan:
1. "L68\n", move_ready=1 -> one move dir=0 dist=68, move_valid one cycle after LF accepted; move_count=1.
2. "R48\r\nL5\n", move_ready low for 6 cycles after first move_valid -> in_ready=0 while stalled, R48 held stable, then L5; err_count=0, move_count=2.
3. "R65535\nR65536\nL1\n" -> moves R65535, L1; err_count=1.
4. "X12\nL\n\nR7\n" -> only R7 emitted; err_count=2 (X line, L with no digits); empty line is not an error.
5. "R9" with in_last on '9' -> R9 emitted; in_ready=0 from next cycle; done=1 one cycle after the move is accepted and stays high.
6. Assert rst_n low mid-stream after "R12", release, send "L3\n" -> only L3 emitted; all counters restart from 0.
